// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered, handshaked RV32I decode stage with output/skid buffer
//
// Decodes one RV32I instruction per transfer into the control fields needed by
// the ID/EX register and buffers up to two decoded entries (SKID=1) or one
// (SKID=0). Optional M-extension decode is enabled by defining DECODE_MULDIV_EN.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 drop all buffered entries and any same-cycle input
//   in_valid/in_ready     fetch-side handshake; in_instr/in_pc are the payload
//   out_valid/out_ready   execute-side handshake
//   out_pc, out_rd/rs1/rs2, out_imm                     operands
//   out_alu_control, out_alu_src, out_alu_a_pc          ALU control
//   out_result_src, out_mem_write, out_mem_funct3       writeback/memory control
//   out_reg_write, out_jump, out_jalr, out_branch, out_br_funct3, out_illegal
module decode_stage #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_alu_control,
  output logic            out_alu_src,
  output logic            out_alu_a_pc,
  output logic [1:0]      out_result_src,
  output logic            out_mem_write,
  output logic [2:0]      out_mem_funct3,
  output logic            out_reg_write,
  output logic            out_jump,
  output logic            out_jalr,
  output logic            out_branch,
  output logic [2:0]      out_br_funct3,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_SUB   = 5'b00001;
  localparam logic [4:0] ALU_AND   = 5'b00010;
  localparam logic [4:0] ALU_OR    = 5'b00011;
  localparam logic [4:0] ALU_XOR   = 5'b00100;
  localparam logic [4:0] ALU_SLT   = 5'b00101;
  localparam logic [4:0] ALU_SLTU  = 5'b00110;
  localparam logic [4:0] ALU_SLL   = 5'b00111;
  localparam logic [4:0] ALU_SRL   = 5'b01000;
  localparam logic [4:0] ALU_SRA   = 5'b01001;
  localparam logic [4:0] ALU_PASSB = 5'b01010;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [4:0]      alu_control;
    logic            alu_src;
    logic            alu_a_pc;
    logic [1:0]      result_src;
    logic            mem_write;
    logic [2:0]      mem_funct3;
    logic            reg_write;
    logic            jump;
    logic            jalr;
    logic            branch;
    logic [2:0]      br_funct3;
    logic            illegal;
  } dec_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  dec_t        dec;
  dec_t        out_q;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  // R-type and undecodable encodings carry a zero immediate.
  always_comb begin
    dec     = '0;
    imm32   = '0;
    dec.pc  = in_pc;
    dec.rs1 = in_instr[19:15];
    dec.rs2 = in_instr[24:20];
    case (opcode)
      OPC_LUI: begin
        dec.reg_write   = 1'b1;
        dec.alu_src     = 1'b1;
        dec.alu_control = ALU_PASSB;
        imm32           = imm_u;
      end
      OPC_AUIPC: begin
        dec.reg_write   = 1'b1;
        dec.alu_src     = 1'b1;
        dec.alu_a_pc    = 1'b1;
        dec.alu_control = ALU_ADD;
        imm32           = imm_u;
      end
      OPC_JAL: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = 2'b10;
        imm32          = imm_j;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          dec.reg_write  = 1'b1;
          dec.jump       = 1'b1;
          dec.jalr       = 1'b1;
          dec.alu_src    = 1'b1;
          dec.result_src = 2'b10;
          imm32          = imm_i;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if (funct3 == 3'b010 || funct3 == 3'b011) begin
          dec.illegal = 1'b1;
        end else begin
          dec.branch      = 1'b1;
          dec.br_funct3   = funct3;
          dec.alu_control = ALU_SUB;
          imm32           = imm_b;
        end
      end
      OPC_LOAD: begin
        case (funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: begin
            dec.reg_write  = 1'b1;
            dec.alu_src    = 1'b1;
            dec.result_src = 2'b01;
            dec.mem_funct3 = funct3;
            imm32          = imm_i;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        case (funct3)
          3'b000, 3'b001, 3'b010: begin
            dec.mem_write  = 1'b1;
            dec.alu_src    = 1'b1;
            dec.mem_funct3 = funct3;
            imm32          = imm_s;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        imm32         = imm_i;
        case (funct3)
          3'b000: dec.alu_control = ALU_ADD;
          3'b010: dec.alu_control = ALU_SLT;
          3'b011: dec.alu_control = ALU_SLTU;
          3'b100: dec.alu_control = ALU_XOR;
          3'b110: dec.alu_control = ALU_OR;
          3'b111: dec.alu_control = ALU_AND;
          3'b001: begin
            if (funct7 == 7'b0000000) dec.alu_control = ALU_SLL;
            else                      dec.illegal     = 1'b1;
          end
          default: begin
            if (funct7 == 7'b0000000)      dec.alu_control = ALU_SRL;
            else if (funct7 == 7'b0100000) dec.alu_control = ALU_SRA;
            else                           dec.illegal     = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        dec.reg_write = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec.alu_control = ALU_ADD;
            3'b001:  dec.alu_control = ALU_SLL;
            3'b010:  dec.alu_control = ALU_SLT;
            3'b011:  dec.alu_control = ALU_SLTU;
            3'b100:  dec.alu_control = ALU_XOR;
            3'b101:  dec.alu_control = ALU_SRL;
            3'b110:  dec.alu_control = ALU_OR;
            default: dec.alu_control = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec.alu_control = ALU_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          dec.alu_control = ALU_SRA;
`ifdef DECODE_MULDIV_EN
        end else if (funct7 == 7'b0000001) begin
          dec.alu_control = {2'b10, funct3};
`endif
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.imm = XLEN'($signed(imm32));
    // An illegal entry must have no architectural side effects downstream.
    if (dec.illegal) begin
      dec.reg_write = 1'b0;
      dec.mem_write = 1'b0;
      dec.jump      = 1'b0;
      dec.jalr      = 1'b0;
      dec.branch    = 1'b0;
    end
    dec.rd = dec.reg_write ? in_instr[11:7] : 5'd0;
  end

  generate
    if (SKID != 0) begin : g_skid
      dec_t skid_q;
      logic out_valid_q;
      logic skid_valid_q;
      logic accept;

      // The skid entry is only ever filled behind a valid output entry, so a
      // valid skid entry means the buffer holds two entries.
      assign accept    = in_valid && !skid_valid_q;
      assign in_ready  = !skid_valid_q;
      assign out_valid = out_valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_q        <= '0;
          skid_q       <= '0;
          out_valid_q  <= 1'b0;
          skid_valid_q <= 1'b0;
        end else if (flush) begin
          out_valid_q  <= 1'b0;
          skid_valid_q <= 1'b0;
        end else if (!out_valid_q) begin
          if (accept) begin
            out_q       <= dec;
            out_valid_q <= 1'b1;
          end
        end else if (out_ready) begin
          if (skid_valid_q) begin
            out_q        <= skid_q;
            skid_valid_q <= 1'b0;
          end else if (accept) begin
            out_q <= dec;
          end else begin
            out_valid_q <= 1'b0;
          end
        end else if (accept) begin
          skid_q       <= dec;
          skid_valid_q <= 1'b1;
        end
      end
    end else begin : g_single
      logic out_valid_q;

      assign in_ready  = !out_valid_q || out_ready;
      assign out_valid = out_valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_q       <= '0;
          out_valid_q <= 1'b0;
        end else if (flush) begin
          out_valid_q <= 1'b0;
        end else if (in_valid && in_ready) begin
          out_q       <= dec;
          out_valid_q <= 1'b1;
        end else if (out_ready) begin
          out_valid_q <= 1'b0;
        end
      end
    end
  endgenerate

  assign out_pc          = out_q.pc;
  assign out_rd          = out_q.rd;
  assign out_rs1         = out_q.rs1;
  assign out_rs2         = out_q.rs2;
  assign out_imm         = out_q.imm;
  assign out_alu_control = out_q.alu_control;
  assign out_alu_src     = out_q.alu_src;
  assign out_alu_a_pc    = out_q.alu_a_pc;
  assign out_result_src  = out_q.result_src;
  assign out_mem_write   = out_q.mem_write;
  assign out_mem_funct3  = out_q.mem_funct3;
  assign out_reg_write   = out_q.reg_write;
  assign out_jump        = out_q.jump;
  assign out_jalr        = out_q.jalr;
  assign out_branch      = out_q.branch;
  assign out_br_funct3   = out_q.br_funct3;
  assign out_illegal     = out_q.illegal;

endmodule
